// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - ISA funct3 encodings and CPU pipeline control-word types
package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

endpackage

package cpuIO;
  import rv32i_types::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
  } exe_ctrl_t;

  typedef struct packed {
    logic       mem_read_d;
    logic       mem_write_d;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic       ld_reg;
    logic [4:0] rd;
  } wb_ctrl_t;

  typedef struct packed {
    logic        valid_commit;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    exe_ctrl_t exe;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    rvfi_t     rvfi;
  } control_word;

  localparam logic [31:0] BUBBLE_PC = 32'h4000_0000;

  // Empty pipeline slot: nothing committed, pc parked at the boot address
  function automatic control_word bubble_cw();
    control_word c;
    c = '0;
    c.rvfi.pc_rdata = BUBBLE_PC;
    return c;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - Data-memory request/response bus between mem_stage and memory
interface mem_stage_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage_align.sv
// rtl/mem_stage_align.sv - Byte-lane steering for loads/stores and alignment check
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [31:0] word_addr,
  output logic [3:0]  byte_enable,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  rmask,
  output logic        misaligned
);

  logic [1:0]  off;
  logic [4:0]  shamt;
  logic [3:0]  lane_mask;
  logic [31:0] rshift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign off       = addr[1:0];
  assign shamt     = {off, 3'b000};
  assign word_addr = {addr[31:2], 2'b00};
  assign rshift    = rdata >> shamt;
  assign ld_byte   = rshift[7:0];
  assign ld_half   = off[1] ? rdata[31:16] : rdata[15:0];

  // Access size lives in funct3[1:0] for both loads and stores
  always_comb begin
    lane_mask  = 4'b1111;
    misaligned = (off != 2'b00);
    wdata      = rs2;
    case (store_funct3_t'({1'b0, funct3[1:0]}))
      sb: begin
        lane_mask  = 4'b0001 << off;
        misaligned = 1'b0;
        wdata      = {24'b0, rs2[7:0]} << shamt;
      end
      sh: begin
        lane_mask  = 4'b0011 << off;
        misaligned = off[0];
        wdata      = {16'b0, rs2[15:0]} << shamt;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and extend it
  always_comb begin
    load_data = rdata;
    case (load_funct3_t'(funct3))
      lb:      load_data = {{24{ld_byte[7]}}, ld_byte};
      lbu:     load_data = {24'b0, ld_byte};
      lh:      load_data = {{16{ld_half[15]}}, ld_half};
      lhu:     load_data = {16'b0, ld_half};
      default: load_data = rdata;
    endcase
  end

  // Misaligned accesses touch no lanes at all
  assign byte_enable = (mem_write && !misaligned) ? lane_mask : 4'b0000;
  assign rmask       = (mem_read && !misaligned) ? lane_mask : 4'b0000;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - Memory stage: load/store sequencing, result register, RVFI fill
module mem_stage
  import cpuIO::*;
(
  input  logic        clk,
  input  logic        rst,
  input  control_word ctrl_w,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_in,
  input  logic        exe_mem_valid,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic        mem_rdy,
  output logic [31:0] mem_fwd_data,
  output control_word rvfi_mem
);

  mem_state_t  state, state_next;
  control_word cw_q;
  logic [31:0] addr_q, rs2_q;
  control_word cw_sel;
  logic [31:0] addr_sel, rs2_sel, rdata_sel;
  logic [31:0] word_addr, wdata, load_data;
  logic [3:0]  byte_enable, rmask;
  logic        misaligned;
  logic        is_mem_op, bad_align, capture, result_load;
  logic        rd_strobe, wr_strobe;
  control_word result_cw;
  logic [31:0] result_fwd;

  // Lane logic sees live inputs while idle and the captured copy once an access is in flight
  always_comb begin
    if (state == IDLE) begin
      cw_sel   = ctrl_w;
      addr_sel = alu_in;
      rs2_sel  = rs2_in;
    end else begin
      cw_sel   = cw_q;
      addr_sel = addr_q;
      rs2_sel  = rs2_q;
    end
    rdata_sel = (state == ACCESS) ? dmem.dmem_rdata : 32'h0;
  end

  mem_align u_align (
    .funct3      (cw_sel.mem.funct3),
    .mem_read    (cw_sel.mem.mem_read_d),
    .mem_write   (cw_sel.mem.mem_write_d),
    .addr        (addr_sel),
    .rs2         (rs2_sel),
    .rdata       (rdata_sel),
    .word_addr   (word_addr),
    .byte_enable (byte_enable),
    .wdata       (wdata),
    .load_data   (load_data),
    .rmask       (rmask),
    .misaligned  (misaligned)
  );

  assign is_mem_op = cw_sel.mem.mem_read_d | cw_sel.mem.mem_write_d;
  assign bad_align = is_mem_op & misaligned;
  assign capture   = (state == IDLE) & exe_mem_valid;

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, memory strobes and pipeline handshake
  always_comb begin
    state_next  = state;
    mem_stall   = 1'b0;
    mem_rdy     = 1'b0;
    rd_strobe   = 1'b0;
    wr_strobe   = 1'b0;
    result_load = 1'b0;
    case (state)
      IDLE: begin
        if (exe_mem_valid && !rst) begin
          if (is_mem_op && !bad_align) begin
            state_next = ACCESS;
            mem_stall  = 1'b1;
          end else begin
            state_next  = DONE;
            result_load = 1'b1;
          end
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        rd_strobe = cw_q.mem.mem_read_d;
        wr_strobe = cw_q.mem.mem_write_d;
        if (dmem.dmem_resp) begin
          state_next  = DONE;
          result_load = 1'b1;
        end
      end
      DONE: begin
        mem_rdy    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Commit record: control word plus the memory fields observed for this instruction
  always_comb begin
    result_fwd = cw_sel.mem.mem_read_d ? load_data : addr_sel;
    result_cw  = cw_sel;
    if (bad_align) begin
      result_cw.wb.ld_reg = 1'b0;
    end
    result_cw.rvfi.valid_commit = 1'b1;
    result_cw.rvfi.mem_addr     = word_addr;
    result_cw.rvfi.mem_rmask    = rmask;
    result_cw.rvfi.mem_wmask    = byte_enable;
    result_cw.rvfi.mem_rdata    = rdata_sel;
    result_cw.rvfi.mem_wdata    = (byte_enable != 4'b0000) ? wdata : 32'h0;
    result_cw.rvfi.rd_wdata     = (result_cw.wb.ld_reg && result_cw.wb.rd != 5'd0) ?
                                  result_fwd : 32'h0;
  end

  // Input capture on accept; output record lives for exactly the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q         <= '0;
      addr_q       <= 32'h0;
      rs2_q        <= 32'h0;
      mem_fwd_data <= 32'h0;
      rvfi_mem     <= bubble_cw();
    end else begin
      if (capture) begin
        cw_q   <= ctrl_w;
        addr_q <= alu_in;
        rs2_q  <= rs2_in;
      end
      if (result_load) begin
        mem_fwd_data <= result_fwd;
        rvfi_mem     <= result_cw;
      end else begin
        rvfi_mem <= bubble_cw();
      end
    end
  end

  assign dmem.dmem_address     = word_addr;
  assign dmem.dmem_read        = rd_strobe;
  assign dmem.dmem_write       = wr_strobe;
  assign dmem.dmem_wdata       = wdata;
  assign dmem.dmem_byte_enable = byte_enable;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ctrl_w  in  control_word  control word from execute (exe/mem/wb/rvfi fields).
REQ-005 alu_in  in  32  execute result; effective address for loads/stores.
REQ-006 rs2_in  in  32  forwarded rs2 value; store data.
REQ-007 exe_mem_valid  in  1  ctrl_w/alu_in/rs2_in hold a valid instruction this cycle.
REQ-008 dmem_address  out  32  word-aligned data-memory address.
REQ-009 dmem_read / dmem_write  out  1 each  data-memory request strobes.
REQ-010 dmem_wdata  out  32  lane-shifted store data.
REQ-011 dmem_byte_enable  out  4  store byte lanes.
REQ-012 dmem_rdata  in  32  read data, valid when dmem_resp=1.
REQ-013 dmem_resp  in  1  single-cycle completion pulse from data memory.
REQ-014 mem_stall  out  1  stage busy; upstream SHALL hold inputs while high.
REQ-015 mem_rdy  out  1  rvfi_mem/mem_fwd_data valid this cycle (one pulse per instruction).
REQ-016 mem_fwd_data  out  32  registered result for forwarding and writeback.
REQ-017 rvfi_mem  out  control_word  registered control word with rvfi mem fields filled.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-019 IDLE: exe_mem_valid and (mem_read_d or mem_write_d) and aligned -> capture inputs, go ACCESS; mem_stall=1 from that cycle.
REQ-020 IDLE: exe_mem_valid, non-memory op or misaligned access -> register ctrl_w to outputs, go DONE; no dmem strobe issued.
REQ-021 ACCESS: dmem_read (or dmem_write) held high with stable address/data/enables until dmem_resp; on dmem_resp go DONE, capture dmem_rdata, strobes low next cycle.
REQ-022 DONE: mem_rdy=1 for exactly one cycle, mem_stall=0, return to IDLE; exe_mem_valid in DONE is accepted next cycle (no back-to-back accept in DONE).
REQ-023 Latency: non-memory op 1 cycle accept->mem_rdy; memory op = dmem_resp cycle + 1.
REQ-024 dmem_address = {alu_in[31:2],2'b00}; off = alu_in[1:0].
REQ-025 Stores: sb -> enable 4'b0001<<off, wdata rs2[7:0] replicated to lane off; sh -> 4'b0011<<off, rs2[15:0] to lane off; sw -> 4'b1111, rs2 unchanged.
REQ-026 Loads: lb/lbu select byte at off, sign/zero extend; lh/lhu select halfword at off[1], sign/zero extend; lw whole word.
REQ-027 Misaligned: sh/lh/lhu with off[0]=1, sw/lw with off!=0 -> rmask=wmask=0, no access, rd write suppressed (wb.ld_reg=0).
REQ-028 mem_fwd_data = extended load data when mem_read_d, else alu_in.
REQ-029 rvfi_mem: mem_addr=dmem_address, rmask/wmask = lane mask, mem_rdata=raw dmem_rdata, mem_wdata=dmem_wdata, rd_wdata=mem_fwd_data if ld_reg and rd!=0 else 0; other fields copied.
REQ-030 rvfi_mem.rvfi.valid_commit=1 only in the mem_rdy cycle; otherwise rvfi_mem is the all-zero bubble with pc_rdata=32'h40000000.
REQ-031 dmem_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-032 rst asserted any cycle (incl. ACCESS) -> state IDLE, dmem_read=dmem_write=0, mem_stall=0, mem_rdy=0, mem_fwd_data=0, rvfi_mem=bubble, immediately (asynchronous).
REQ-033 An access aborted by reset SHALL NOT commit; a late dmem_resp after reset is ignored.

Structure
REQ-034 mem_state_t enum (IDLE/ACCESS/DONE) SHALL live in cpuIO; load/store funct3 enums stay in rv32i_types.
REQ-035 Lane logic (enable, wdata shift, load extract/extend, mask, misalign flag) SHALL be one combinational sub-module mem_align.

Verification
REQ-036 sw alu_in=0x00001000, rs2=0xDEADBEEF, resp after 3 cycles -> address 0x1000, enable 1111, write held 3 cycles, mem_rdy 1 cycle later, wmask 1111.
REQ-037 lb alu_in=0x00002003, rdata=0x80FF7F01 -> read address 0x2000, mem_fwd_data 0xFFFFFF80, rmask 1000; lbu same -> 0x00000080.
REQ-038 sh alu_in=0x102, rs2=0x0000ABCD -> enable 1100, wdata 0xABCD0000; lw alu_in=0x102 -> no strobe, masks 0, ld_reg 0, mem_rdy next cycle.
REQ-039 add (non-memory) alu_in=0x55 -> no strobe, mem_rdy next cycle, mem_fwd_data 0x55, valid_commit 1.
REQ-040 rst pulsed mid-ACCESS, then dmem_resp -> strobes drop same cycle, no mem_rdy, no commit.
